// File: rtl/axis_selector_pkg.sv
// Shared constants, channel FSM encoding and width adaptation for the selector matrix.
package axis_selector_pkg;

  localparam int SEL_W           = 8;
  localparam int CFG_WORD_W      = 32;
  localparam int WORD_TEST_MASK  = 4;
  localparam int WORD_TEST_VALUE = 5;
  localparam int WORD_SYNC_MASK  = 6;
  localparam int TEST_VALUE_W    = 32;
  localparam int ADAPT_W         = 512;

  typedef enum logic [0:0] {
    ST_ACTIVE  = 1'b0,
    ST_PENDING = 1'b1
  } chan_state_t;

  // Left-align the source at the top of a wide signed word, then shift back down:
  // widening keeps the LSB position (sign-extend), narrowing keeps the MSBs (full-scale).
  function automatic logic [ADAPT_W-1:0] width_adapt(input logic [ADAPT_W-1:0] din,
                                                     input int src_w, input int dst_w);
    logic signed [ADAPT_W-1:0] aligned;
    aligned = $signed(din << (ADAPT_W - src_w));
    return $unsigned(aligned >>> ((dst_w >= src_w) ? (ADAPT_W - src_w) : (ADAPT_W - dst_w)));
  endfunction

endpackage

// File: rtl/axis_selector_channel.sv
// One output: select FSM with deferred switching, mux, width adapt, output register.
// One cycle from registered sources to output; sources are never back-pressured.
module axis_selector_channel
  import axis_selector_pkg::*;
#(
  parameter int NUM_S             = 16,
  parameter int SAXIS_TDATA_WIDTH = 32,
  parameter int MAXIS_TDATA_WIDTH = 32,
  parameter int SWITCH_TIMEOUT    = 1024
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic [SEL_W-1:0]                   sel,
  input  logic                               load,
  input  logic                               sync_en,
  input  logic                               test_en,
  input  logic [TEST_VALUE_W-1:0]            test_value,
  input  logic [NUM_S*SAXIS_TDATA_WIDTH-1:0] src_data,
  input  logic [NUM_S-1:0]                   src_valid,
  output logic [MAXIS_TDATA_WIDTH-1:0]       data,
  output logic                               valid,
  output logic                               pending
);

  localparam int SW    = SAXIS_TDATA_WIDTH;
  localparam int MW    = MAXIS_TDATA_WIDTH;
  localparam int NSEL  = 2 ** SEL_W;
  localparam int CNT_W = (SWITCH_TIMEOUT > 1) ? $clog2(SWITCH_TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SWITCH_TIMEOUT - 1);

  // Pad the source set to the full selector range so out-of-range selects read zero data/valid.
  logic [SW-1:0]   src_arr [NSEL];
  logic [NSEL-1:0] valid_ext;

  for (genvar k = 0; k < NSEL; k++) begin : g_src
    if (k < NUM_S) begin : g_used
      assign src_arr[k] = src_data[k*SW +: SW];
    end else begin : g_pad
      assign src_arr[k] = '0;
    end
  end
  assign valid_ext = NSEL'(src_valid);

  chan_state_t      state;
  logic [SEL_W-1:0] cur_sel;
  logic [SEL_W-1:0] eff_sel;
  logic [CNT_W-1:0] cnt;
  logic             new_valid;
  logic [ADAPT_W-1:0] src_adapted;
  logic [ADAPT_W-1:0] test_adapted;
  logic             adapt_unused;

  assign new_valid    = valid_ext[sel];
  assign pending      = (state == ST_PENDING);
  assign adapt_unused = ^{src_adapted, test_adapted};

  // The sample that releases a pending switch is routed in the same cycle it is seen.
  always_comb begin
    eff_sel = cur_sel;
    if (state == ST_PENDING && new_valid) eff_sel = sel;
    src_adapted  = width_adapt(ADAPT_W'(src_arr[eff_sel]), SW, MW);
    test_adapted = width_adapt(ADAPT_W'(test_value), TEST_VALUE_W, MW);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_ACTIVE;
      cur_sel <= '0;
      cnt     <= '0;
    end else begin
      case (state)
        ST_ACTIVE: begin
          if (sel != cur_sel) begin
            if (sync_en) begin
              state <= ST_PENDING;
              cnt   <= '0;
            end else begin
              cur_sel <= sel;
            end
          end
        end
        ST_PENDING: begin
          if (sel == cur_sel) begin
            state <= ST_ACTIVE;
          end else if (new_valid) begin
            cur_sel <= sel;
            state   <= ST_ACTIVE;
          end else if (load) begin
            cnt <= '0;
          end else if (cnt == CNT_LAST) begin
            cur_sel <= sel;
            state   <= ST_ACTIVE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= ST_ACTIVE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data  <= '0;
      valid <= 1'b0;
    end else if (test_en) begin
      data  <= test_adapted[MW-1:0];
      valid <= 1'b1;
    end else begin
      data  <= src_adapted[MW-1:0];
      valid <= valid_ext[eff_sel];
    end
  end

endmodule

// File: rtl/axis_selector_matrix.sv
// AXI-Stream crosspoint: any of NUM_S sources to each of NUM_M outputs, config-bus programmed.
// Two cycles source to output (input register + output register); no tready, never stalls.
module axis_selector_matrix
  import axis_selector_pkg::*;
#(
  parameter int NUM_S                 = 16,
  parameter int NUM_M                 = 6,
  parameter int SAXIS_TDATA_WIDTH     = 32,
  parameter int MAXIS_TDATA_WIDTH     = 32,
  parameter int SWITCH_TIMEOUT        = 1024,
  parameter int configuration_address = 2000
) (
  input  logic                               a_clk,
  input  logic                               a_resetn,
  input  logic [31:0]                        config_addr,
  input  logic [511:0]                       config_data,
  input  logic [NUM_S*SAXIS_TDATA_WIDTH-1:0] S_AXIS_tdata,
  input  logic [NUM_S-1:0]                   S_AXIS_tvalid,
  output logic [NUM_M*MAXIS_TDATA_WIDTH-1:0] M_AXIS_tdata,
  output logic [NUM_M-1:0]                   M_AXIS_tvalid,
  output logic [NUM_M-1:0]                   switch_pending
);

  localparam int MW = MAXIS_TDATA_WIDTH;

  logic [SEL_W-1:0]                   sel_reg [NUM_M];
  logic [NUM_M-1:0]                   test_mask;
  logic [NUM_M-1:0]                   sync_mask;
  logic [TEST_VALUE_W-1:0]            test_value;
  logic                               cfg_load;
  logic                               cfg_hit;
  logic                               cfg_unused;
  logic [NUM_S*SAXIS_TDATA_WIDTH-1:0] s_data_r;
  logic [NUM_S-1:0]                   s_valid_r;

  assign cfg_hit    = (config_addr == 32'(configuration_address));
  assign cfg_unused = ^config_data;

  // cfg_load marks the cycle the new settings are visible, so a pending switch can restart its timeout.
  always_ff @(posedge a_clk or negedge a_resetn) begin
    if (!a_resetn) begin
      for (int j = 0; j < NUM_M; j++) sel_reg[j] <= '0;
      test_mask  <= '0;
      sync_mask  <= '0;
      test_value <= '0;
      cfg_load   <= 1'b0;
    end else begin
      cfg_load <= cfg_hit;
      if (cfg_hit) begin
        for (int j = 0; j < NUM_M; j++) sel_reg[j] <= config_data[j*SEL_W +: SEL_W];
        test_mask  <= config_data[WORD_TEST_MASK*CFG_WORD_W +: NUM_M];
        test_value <= config_data[WORD_TEST_VALUE*CFG_WORD_W +: TEST_VALUE_W];
        sync_mask  <= config_data[WORD_SYNC_MASK*CFG_WORD_W +: NUM_M];
      end
    end
  end

  always_ff @(posedge a_clk or negedge a_resetn) begin
    if (!a_resetn) begin
      s_data_r  <= '0;
      s_valid_r <= '0;
    end else begin
      s_data_r  <= S_AXIS_tdata;
      s_valid_r <= S_AXIS_tvalid;
    end
  end

  for (genvar j = 0; j < NUM_M; j++) begin : g_chan
    axis_selector_channel #(
      .NUM_S             (NUM_S),
      .SAXIS_TDATA_WIDTH (SAXIS_TDATA_WIDTH),
      .MAXIS_TDATA_WIDTH (MAXIS_TDATA_WIDTH),
      .SWITCH_TIMEOUT    (SWITCH_TIMEOUT)
    ) u_chan (
      .clk        (a_clk),
      .rst_n      (a_resetn),
      .sel        (sel_reg[j]),
      .load       (cfg_load),
      .sync_en    (sync_mask[j]),
      .test_en    (test_mask[j]),
      .test_value (test_value),
      .src_data   (s_data_r),
      .src_valid  (s_valid_r),
      .data       (M_AXIS_tdata[j*MW +: MW]),
      .valid      (M_AXIS_tvalid[j]),
      .pending    (switch_pending[j])
    );
  end

endmodule

// File: tb/tb_axis_selector_matrix.sv
// Randomised + directed bench for axis_selector_matrix with an in-bench routing model.
module tb_axis_selector_matrix;

  localparam int NS = 16;
  localparam int NM = 6;
  localparam int W  = 32;
  localparam int TO = 64;

  logic a_clk = 1'b0;
  logic a_resetn = 1'b0;
  always #5 a_clk = ~a_clk;

  logic [31:0]      config_addr;
  logic [511:0]     config_data;
  logic [NS*W-1:0]  s_tdata;
  logic [NS-1:0]    s_tvalid;
  logic [NM*W-1:0]  m_tdata;
  logic [NM-1:0]    m_tvalid;
  logic [NM-1:0]    sw_pend;

  logic [8*32-1:0]  n_sdata;
  logic [7:0]       n_svalid;
  logic [15:0]      n_mdata;
  logic [0:0]       n_mvalid, n_pend;
  logic [8*16-1:0]  w_sdata;
  logic [7:0]       w_svalid;
  logic [31:0]      w_mdata;
  logic [0:0]       w_mvalid, w_pend;

  axis_selector_matrix #(.NUM_S(NS), .NUM_M(NM), .SAXIS_TDATA_WIDTH(W), .MAXIS_TDATA_WIDTH(W),
                         .SWITCH_TIMEOUT(TO), .configuration_address(2000)) u_dut (
    .a_clk(a_clk), .a_resetn(a_resetn), .config_addr(config_addr), .config_data(config_data),
    .S_AXIS_tdata(s_tdata), .S_AXIS_tvalid(s_tvalid),
    .M_AXIS_tdata(m_tdata), .M_AXIS_tvalid(m_tvalid), .switch_pending(sw_pend));

  axis_selector_matrix #(.NUM_S(8), .NUM_M(1), .SAXIS_TDATA_WIDTH(32), .MAXIS_TDATA_WIDTH(16),
                         .SWITCH_TIMEOUT(16), .configuration_address(2001)) u_narrow (
    .a_clk(a_clk), .a_resetn(a_resetn), .config_addr(config_addr), .config_data(config_data),
    .S_AXIS_tdata(n_sdata), .S_AXIS_tvalid(n_svalid),
    .M_AXIS_tdata(n_mdata), .M_AXIS_tvalid(n_mvalid), .switch_pending(n_pend));

  axis_selector_matrix #(.NUM_S(8), .NUM_M(1), .SAXIS_TDATA_WIDTH(16), .MAXIS_TDATA_WIDTH(32),
                         .SWITCH_TIMEOUT(16), .configuration_address(2002)) u_wide (
    .a_clk(a_clk), .a_resetn(a_resetn), .config_addr(config_addr), .config_data(config_data),
    .S_AXIS_tdata(w_sdata), .S_AXIS_tvalid(w_svalid),
    .M_AXIS_tdata(w_mdata), .M_AXIS_tvalid(w_mvalid), .switch_pending(w_pend));

  int n_checks = 0;
  int n_err = 0;
  bit chk_en = 0;

  task automatic check(input string name, input logic [191:0] act, input logic [191:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model of the main instance ----------------
  // Each output has a committed source and optionally a requested one with a deadline cycle.
  logic [W-1:0]   r_d [NS];
  bit             r_v [NS];
  int             m_sel [NM];
  logic [NM-1:0]  m_test, m_sync;
  logic [31:0]    m_tval;
  bit             m_reload;
  int             committed [NM];
  bit             pend [NM];
  int             deadline [NM];
  int             ncyc;
  logic [NM*W-1:0] exp_d;
  logic [NM-1:0]   exp_v, exp_p;

  function automatic logic [W-1:0] rd(input int s);
    return (s < NS) ? r_d[s] : '0;
  endfunction
  function automatic bit rv(input int s);
    return (s < NS) ? r_v[s] : 1'b0;
  endfunction

  task automatic mdl_reset();
    for (int k = 0; k < NS; k++) begin r_d[k] = '0; r_v[k] = 0; end
    for (int j = 0; j < NM; j++) begin m_sel[j] = 0; committed[j] = 0; pend[j] = 0; deadline[j] = 0; end
    m_test = '0; m_sync = '0; m_tval = '0; m_reload = 0; ncyc = 0;
    exp_d = '0; exp_v = '0; exp_p = '0;
  endtask

  task automatic mdl_edge();
    ncyc++;
    for (int j = 0; j < NM; j++) begin
      int src;
      int want;
      want = m_sel[j];
      src = (pend[j] && rv(want)) ? want : committed[j];
      if (m_test[j]) begin
        exp_d[j*W +: W] = m_tval;
        exp_v[j] = 1'b1;
      end else begin
        exp_d[j*W +: W] = rd(src);
        exp_v[j] = rv(src);
      end
      if (!pend[j]) begin
        if (want != committed[j]) begin
          if (m_sync[j]) begin pend[j] = 1; deadline[j] = ncyc + TO; end
          else committed[j] = want;
        end
      end else if (want == committed[j]) begin
        pend[j] = 0;
      end else if (rv(want)) begin
        committed[j] = want; pend[j] = 0;
      end else if (m_reload) begin
        deadline[j] = ncyc + TO;
      end else if (ncyc == deadline[j]) begin
        committed[j] = want; pend[j] = 0;
      end
      exp_p[j] = pend[j];
    end
    m_reload = (config_addr == 32'd2000);
    if (m_reload) begin
      for (int j = 0; j < NM; j++) m_sel[j] = int'(config_data[8*j +: 8]);
      m_test = config_data[128 +: NM];
      m_tval = config_data[160 +: 32];
      m_sync = config_data[192 +: NM];
    end
    for (int k = 0; k < NS; k++) begin r_d[k] = s_tdata[k*W +: W]; r_v[k] = s_tvalid[k]; end
  endtask

  initial forever begin
    @(posedge a_clk or negedge a_resetn);
    if (!a_resetn) mdl_reset();
    else mdl_edge();
  end

  initial forever begin
    @(negedge a_clk);
    if (chk_en && a_resetn) begin
      check("model_tdata", 192'(m_tdata), 192'(exp_d));
      check("model_tvalid", 192'(m_tvalid), 192'(exp_v));
      check("model_pending", 192'(sw_pend), 192'(exp_p));
    end
  end

  // ---------------- stimulus helpers ----------------
  logic [7:0]    cfg_sel [NM];
  logic [NM-1:0] cfg_test, cfg_sync;
  logic [31:0]   cfg_tval;

  task automatic tick();
    @(posedge a_clk);
    @(negedge a_clk);
  endtask

  task automatic set_src(input int k, input logic [31:0] d, input logic v);
    s_tdata[k*W +: W] = d;
    s_tvalid[k] = v;
  endtask

  task automatic write_main();
    config_data = '0;
    for (int j = 0; j < NM; j++) config_data[8*j +: 8] = cfg_sel[j];
    config_data[128 +: NM] = cfg_test;
    config_data[160 +: 32] = cfg_tval;
    config_data[192 +: NM] = cfg_sync;
    config_addr = 32'd2000;
    tick();
    config_addr = '0;
  endtask

  task automatic aux_write(input int addr, input logic [7:0] sel, input logic test,
                           input logic [31:0] tval, input logic sync);
    config_data = '0;
    config_data[7:0] = sel;
    config_data[128] = test;
    config_data[160 +: 32] = tval;
    config_data[192] = sync;
    config_addr = 32'(addr);
    tick();
    config_addr = '0;
  endtask

  initial begin
    int pcount;
    config_addr = '0; config_data = '0;
    s_tdata = '0; s_tvalid = '0;
    n_sdata = '0; n_svalid = '0; w_sdata = '0; w_svalid = '0;
    for (int j = 0; j < NM; j++) cfg_sel[j] = '0;
    cfg_test = '0; cfg_sync = '0; cfg_tval = '0;

    repeat (3) tick();
    check("reset_tdata", 192'(m_tdata), 192'(0));
    check("reset_tvalid", 192'(m_tvalid), 192'(0));
    check("reset_pending", 192'(sw_pend), 192'(0));
    check("reset_aux", 192'({n_mdata, w_mdata, n_mvalid, w_mvalid}), 192'(0));
    a_resetn = 1'b1;
    chk_en = 1;

    // Ramp on source 3 routed to output 1; the value applied before the previous edge is visible now.
    cfg_sel[1] = 8'd3;
    write_main();
    for (int i = 0; i < 12; i++) begin
      set_src(3, 32'(i), 1'b1);
      tick();
      if (i == 0) check("ramp_not_yet", 192'(m_tvalid[1]), 192'(0));
      if (i >= 1) begin
        check("ramp_data", 192'(m_tdata[63:32]), 192'(i - 1));
        check("ramp_valid", 192'(m_tvalid[1]), 192'(1));
      end
    end

    // Deferred switch on output 2 from source 1 to source 5, released by a pulse 40 cycles later.
    set_src(1, 32'h1111, 1'b1);
    set_src(5, 32'h0, 1'b0);
    cfg_sel[2] = 8'd1;
    write_main();
    repeat (3) tick();
    check("sync_before", 192'(m_tdata[95:64]), 192'(32'h1111));
    cfg_sel[2] = 8'd5;
    cfg_sync[2] = 1'b1;
    write_main();
    pcount = 0;
    for (int t = 1; t <= 60; t++) begin
      if (t == 40) set_src(5, 32'hABCD, 1'b1);
      else if (t == 41) set_src(5, 32'h5555, 1'b0);
      tick();
      if (sw_pend[2]) pcount++;
      if (t == 40) check("sync_last_old", 192'(m_tdata[95:64]), 192'(32'h1111));
      if (t == 41) begin
        check("sync_first_new", 192'(m_tdata[95:64]), 192'(32'hABCD));
        check("sync_first_valid", 192'(m_tvalid[2]), 192'(1));
      end
    end
    check("sync_pending_cycles", 192'(pcount), 192'(40));
    cfg_sync[2] = 1'b0;

    // Test-value injection on output 4 with source 0 silent, then release.
    set_src(0, 32'h0BADF00D, 1'b0);
    cfg_test[4] = 1'b1;
    cfg_tval = 32'h12345678;
    write_main();
    for (int i = 0; i < 5; i++) begin
      tick();
      check("inject_data", 192'(m_tdata[159:128]), 192'(32'h12345678));
      check("inject_valid", 192'(m_tvalid[4]), 192'(1));
    end
    cfg_test[4] = 1'b0;
    set_src(0, 32'h0BADF00D, 1'b1);
    write_main();
    tick();
    check("inject_release", 192'({m_tvalid[4], m_tdata[159:128]}), 192'({1'b1, 32'h0BADF00D}));

    // Out-of-range select: every source carries nonzero valid data.
    for (int k = 0; k < NS; k++) set_src(k, 32'hC0DE0000 | 32'(k), 1'b1);
    cfg_sel[3] = 8'd200;
    write_main();
    repeat (3) tick();
    check("oor_select", 192'({m_tvalid[3], m_tdata[127:96]}), 192'(0));

    // Reset while output 5 waits on silent source 9.
    set_src(9, 32'h9999, 1'b0);
    cfg_sel[5] = 8'd9;
    cfg_sync[5] = 1'b1;
    write_main();
    repeat (5) tick();
    check("pending_before_reset", 192'(sw_pend[5]), 192'(1));
    @(posedge a_clk);
    #2 a_resetn = 1'b0;
    #1;
    check("async_reset_out", 192'({m_tdata, m_tvalid, sw_pend}), 192'(0));
    @(negedge a_clk);
    a_resetn = 1'b1;
    for (int j = 0; j < NM; j++) cfg_sel[j] = '0;
    cfg_test = '0; cfg_sync = '0; cfg_tval = '0;
    repeat (3) tick();
    check("after_reset_sel0", 192'({m_tvalid[5], m_tdata[191:160]}), 192'({1'b1, 32'hC0DE0000}));
    check("after_reset_pending", 192'(sw_pend), 192'(0));

    // Width adaptation and timeout on the auxiliary instances.
    n_sdata[2*32 +: 32] = 32'hFFFF0001; n_svalid[2] = 1'b1;
    aux_write(2001, 8'd2, 1'b0, 32'h0, 1'b0);
    repeat (3) tick();
    check("narrow_msb", 192'({n_mvalid, n_mdata}), 192'({1'b1, 16'hFFFF}));
    aux_write(2001, 8'd2, 1'b1, 32'h12345678, 1'b0);
    tick();
    check("narrow_test", 192'(n_mdata), 192'(16'h1234));
    aux_write(2001, 8'd7, 1'b0, 32'h0, 1'b1);
    pcount = 0;
    for (int t = 0; t < 40; t++) begin
      tick();
      if (n_pend[0]) pcount++;
    end
    check("timeout_cycles", 192'(pcount), 192'(16));
    check("timeout_out", 192'({n_pend, n_mvalid, n_mdata}), 192'(0));

    w_sdata[1*16 +: 16] = 16'h8000; w_svalid[1] = 1'b1;
    aux_write(2002, 8'd1, 1'b0, 32'h0, 1'b0);
    repeat (3) tick();
    check("wide_sext_neg", 192'({w_mvalid, w_mdata}), 192'({1'b1, 32'hFFFF8000}));
    w_sdata[1*16 +: 16] = 16'h1234;
    repeat (2) tick();
    check("wide_sext_pos", 192'(w_mdata), 192'(32'h00001234));

    // Random traffic: sources 8..11 rarely valid, 12..15 silent, selects up to 19 plus 200.
    for (int cyc = 0; cyc < 3000; cyc++) begin
      for (int k = 0; k < NS; k++) begin
        logic v;
        if (k < 8) v = 1'($urandom_range(0, 1));
        else if (k < 12) v = ($urandom_range(0, 31) == 0);
        else v = 1'b0;
        set_src(k, $urandom, v);
      end
      if ($urandom_range(0, 24) == 0) begin
        for (int j = 0; j < NM; j++)
          cfg_sel[j] = ($urandom_range(0, 9) == 0) ? 8'd200 : 8'($urandom_range(0, 19));
        cfg_test = NM'($urandom & $urandom & $urandom);
        cfg_sync = NM'($urandom);
        cfg_tval = $urandom;
        write_main();
      end else begin
        tick();
      end
    end

    chk_en = 0;
    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end

endmodule
